// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - registered, handshaked LEGv8 main control decoder with output FIFO
//
// Purpose:
//    Decodes each accepted 11-bit opcode (instruction bits [31:21]) into the
//    LEGv8 main-control vector plus an illegal flag. The result is queued in a
//    DEPTH-entry FIFO with valid/ready flow control. A flush empties the queue.
//    A saturating counter tracks accepted illegal opcodes.
//
// Configuration macro:
//    DECODE_BRANCH_EN - when defined, CBZ (10110100xxx) and B (000101xxxxx)
//                       decode to branch controls. Otherwise both decode as
//                       illegal and UncondBranch is tied to 0.
//
// Ports:
//    clk          rising-edge clock
//    reset        synchronous, active-high reset
//    flush        drops all queued entries and any concurrent push
//    in_valid     opcode present
//    in_ready     block can accept an opcode (count < DEPTH, low during reset)
//    opcode       instruction bits [31:21]
//    out_valid    head entry valid
//    out_ready    consumer takes the head entry
//    Reg2Loc..UncondBranch, ALUOp
//                 control fields of the head entry (0 when out_valid=0)
//    illegal      head entry opcode is undecodable (0 when out_valid=0)
//    illegal_cnt  saturating count of accepted illegal opcodes
module pipelined_control_unit #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [10:0]      opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             Reg2Loc,
   output logic             ALUSrc,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Branch,
   output logic             UncondBranch,
   output logic [1:0]       ALUOp,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Entry layout:
   //    [0] Reg2Loc  [1] ALUSrc  [2] MemtoReg  [3] RegWrite
   //    [4] MemRead  [5] MemWrite [6] Branch   [8:7] ALUOp
   //    [9] illegal  [10] UncondBranch (only stored when branches decode)
`ifdef DECODE_BRANCH_EN
   localparam int EW = 11;
`else
   localparam int EW = 10;
`endif

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] dec;
   logic [EW-1:0] head_entry;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic          push;
   logic          pop;

   // in_ready depends only on the count register (and reset), so there is no
   // combinational path from out_ready; a full FIFO cannot take a word in the
   // same cycle it pops.
   assign in_ready  = !reset && (count < (PW+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      dec    = '0;
      dec[9] = 1'b1;
      casez (opcode)
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: begin
            dec[9]   = 1'b0;
            dec[3]   = 1'b1;
            dec[8:7] = 2'b10;
         end
         11'b11111000010: begin
            dec[9] = 1'b0;
            dec[1] = 1'b1;
            dec[2] = 1'b1;
            dec[3] = 1'b1;
            dec[4] = 1'b1;
         end
         11'b11111000000: begin
            dec[9] = 1'b0;
            dec[0] = 1'b1;
            dec[1] = 1'b1;
            dec[5] = 1'b1;
         end
`ifdef DECODE_BRANCH_EN
         11'b10110100???: begin
            dec[9]   = 1'b0;
            dec[0]   = 1'b1;
            dec[6]   = 1'b1;
            dec[8:7] = 2'b01;
         end
         11'b000101?????: begin
            dec[9]  = 1'b0;
            dec[10] = 1'b1;
         end
`endif
         default: dec[9] = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         illegal_cnt <= '0;
      end else begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         // push already excludes flush, so an ignored illegal opcode is not counted
         if (push && dec[9] && (illegal_cnt != {CNT_W{1'b1}}))
            illegal_cnt <= illegal_cnt + 1'b1;
      end
   end

   // Storage needs no reset: out_valid masks every stale entry.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= dec;
   end

   assign head_entry = out_valid ? mem[head] : '0;

   assign Reg2Loc  = head_entry[0];
   assign ALUSrc   = head_entry[1];
   assign MemtoReg = head_entry[2];
   assign RegWrite = head_entry[3];
   assign MemRead  = head_entry[4];
   assign MemWrite = head_entry[5];
   assign Branch   = head_entry[6];
   assign ALUOp    = head_entry[8:7];
   assign illegal  = head_entry[9];
`ifdef DECODE_BRANCH_EN
   assign UncondBranch = head_entry[10];
`else
   assign UncondBranch = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed self-checking bench for pipelined_control_unit
module tb_pipelined_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [10:0] opcode;
   logic       out_valid;
   logic       out_ready;
   logic       Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch;
   logic [1:0] ALUOp;
   logic       illegal;
   logic [1:0] illegal_cnt;

   int errors = 0;
   int checks = 0;

   // Observed vector: Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,UncondBranch,ALUOp,illegal
   logic [10:0] obs;
   assign obs = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                 Branch, UncondBranch, ALUOp, illegal};

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_ILL  = 11'b11111111111;
   localparam logic [10:0] OP_CBZ  = 11'b10110100101;
   localparam logic [10:0] OP_B    = 11'b00010100000;

   localparam logic [10:0] V_RTYPE = 11'b00010000100;
   localparam logic [10:0] V_LDUR  = 11'b01111000000;
   localparam logic [10:0] V_STUR  = 11'b11000100000;
   localparam logic [10:0] V_CBZ   = 11'b10000010010;
   localparam logic [10:0] V_B     = 11'b00000001000;
   localparam logic [10:0] V_ILL   = 11'b00000000001;

   pipelined_control_unit #(.DEPTH(2), .CNT_W(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .out_valid(out_valid), .out_ready(out_ready),
      .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .UncondBranch(UncondBranch),
      .ALUOp(ALUOp), .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [10:0] s_ops  [4];
   logic [10:0] s_vecs [4];

   initial begin
      s_ops[0] = OP_ADD;  s_vecs[0] = V_RTYPE;
      s_ops[1] = OP_SUB;  s_vecs[1] = V_RTYPE;
      s_ops[2] = OP_LDUR; s_vecs[2] = V_LDUR;
      s_ops[3] = OP_STUR; s_vecs[3] = V_STUR;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0;
      @(negedge clk);
      tick();
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_vec", 32'(obs), 32'd0);
      check_eq("rst_cnt", 32'(illegal_cnt), 32'd0);
      reset = 1'b0;
      #1;
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

      // single ADD, one-cycle latency
      in_valid = 1'b1; opcode = OP_ADD; out_ready = 1'b1;
      tick();
      check_eq("add_valid", 32'(out_valid), 32'd1);
      check_eq("add_vec", 32'(obs), 32'(V_RTYPE));
      in_valid = 1'b0;
      tick();
      check_eq("add_drained", 32'(out_valid), 32'd0);
      check_eq("idle_vec_zero", 32'(obs), 32'd0);

      // flush with two entries queued and a concurrent illegal push
      out_ready = 1'b0; in_valid = 1'b1; opcode = OP_ADD;
      tick();
      opcode = OP_LDUR;
      tick();
      check_eq("flush_pre_full", 32'(in_ready), 32'd0);
      flush = 1'b1; opcode = OP_ILL;
      tick();
      check_eq("flush_out_valid", 32'(out_valid), 32'd0);
      check_eq("flush_in_ready", 32'(in_ready), 32'd1);
      check_eq("flush_vec", 32'(obs), 32'd0);
      check_eq("flush_cnt", 32'(illegal_cnt), 32'd0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      check_eq("flush_no_ghost", 32'(out_valid), 32'd0);

      // LDUR then STUR back-to-back, consumer stalled
      in_valid = 1'b1; opcode = OP_LDUR;
      tick();
      opcode = OP_STUR;
      tick();
      in_valid = 1'b0;
      check_eq("full_in_ready", 32'(in_ready), 32'd0);
      check_eq("ldur_head", 32'(obs), 32'(V_LDUR));
      out_ready = 1'b1;
      tick();
      check_eq("stur_head", 32'(obs), 32'(V_STUR));
      check_eq("after_pop_in_ready", 32'(in_ready), 32'd1);
      tick();
      check_eq("ls_drained", 32'(out_valid), 32'd0);

      // illegal opcode four times, counter saturates at 3
      in_valid = 1'b1; opcode = OP_ILL;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_eq($sformatf("ill_vec_%0d", k), 32'(obs), 32'(V_ILL));
         check_eq($sformatf("ill_cnt_%0d", k), 32'(illegal_cnt), (k > 3) ? 32'd3 : 32'(k));
      end
      in_valid = 1'b0;
      tick();
      check_eq("ill_drained", 32'(out_valid), 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("cnt_survives_flush", 32'(illegal_cnt), 32'd3);

      // reset mid-stream discards entries and clears the counter
      out_ready = 1'b0; in_valid = 1'b1; opcode = OP_ADD;
      tick();
      tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_cnt", 32'(illegal_cnt), 32'd0);
      check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check_eq("midrst_release_ready", 32'(in_ready), 32'd1);

      // branch opcodes
      out_ready = 1'b1; in_valid = 1'b1; opcode = OP_CBZ;
      tick();
`ifdef DECODE_BRANCH_EN
      check_eq("cbz_vec", 32'(obs), 32'(V_CBZ));
`else
      check_eq("cbz_vec", 32'(obs), 32'(V_ILL));
`endif
      opcode = OP_B;
      tick();
`ifdef DECODE_BRANCH_EN
      check_eq("b_vec", 32'(obs), 32'(V_B));
`else
      check_eq("b_vec", 32'(obs), 32'(V_ILL));
`endif
      in_valid = 1'b0;
      tick();
`ifdef DECODE_BRANCH_EN
      check_eq("branch_cnt", 32'(illegal_cnt), 32'd0);
`else
      check_eq("branch_cnt", 32'(illegal_cnt), 32'd2);
`endif

      // continuous push and pop across pointer wrap
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         opcode = s_ops[i % 4];
         tick();
         check_eq($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
         check_eq($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
         check_eq($sformatf("stream_vec_%0d", i), 32'(obs), 32'(s_vecs[i % 4]));
      end
      in_valid = 1'b0;
      tick();
      check_eq("stream_drained", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
